mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the DataMemory interface. Takes byte, halfword and word load/store requests from the multi-cycle control FSM.
- Drives the word-wide DataMemory port (data_address, write_en, write_data) and captures read_data.
- Returns aligned, sign- or zero-extended load data, which feeds the memory data register path.
- Sub-word stores use read-modify-write, because DataMemory has no byte enables.

Parameters:
- ADDR_W, 16, DataMemory word-address width (width of mem_address)
- DATA_W, 32, data word width; fixed at 32 (byte-lane logic assumes 4 lanes)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req_valid  in  1  request strobe; sampled only when req_ready=1
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
- req_addr  in  ADDR_W+2  byte address; word index = req_addr[ADDR_W+1:2], lane = req_addr[1:0]
- req_wdata  in  DATA_W  store data, right-justified
- req_ready  out  1  unit idle, request may be accepted
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  load result; 0 for stores and errors
- resp_error  out  1  misaligned or illegal-size request; valid with resp_valid
- mem_address  out  ADDR_W  to DataMemory data_address
- mem_write_en  out  1  to DataMemory write_en
- mem_write_data  out  DATA_W  to DataMemory write_data
- mem_read_data  in  DATA_W  from DataMemory read_data (combinational read)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- All outputs except req_ready are registered.
- Reset values: state=IDLE; mem_address=0; mem_write_en=0; mem_write_data=0; resp_valid=0; resp_rdata=0; resp_error=0.
- req_ready = (state==IDLE) && !rst.
- FSM states: IDLE, READ, WRITE, RESP.
- Acceptance: in IDLE with req_valid=1, latch the request and set mem_address = word index.
- Transitions out of IDLE:
  - Misaligned or illegal request -> RESP with error; no memory access.
  - Load -> READ.
  - Word store -> WRITE, with mem_write_data=req_wdata.
  - Byte/half store -> READ.
- READ: at the end of the cycle, sample mem_read_data (address stable for the whole cycle).
  - Load -> RESP; resp_rdata = extracted lane, extended.
  - Sub-word store -> WRITE; mem_write_data = sampled word with the target lane(s) replaced by req_wdata[7:0] or [15:0].
- WRITE: mem_write_en=1 for exactly this one cycle; address and data held stable throughout. Next state RESP.
- RESP: resp_valid=1 for one cycle, resp_error per request. Next state IDLE; outputs return to 0, and resp_rdata holds until the next response.
- Latency from the acceptance edge to resp_valid:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- No response back-pressure. Back-to-back requests allowed: IDLE is re-entered the cycle after RESP.
- Endianness: little-endian. Byte lane n = bits [8n+7:8n]; a half at lane 0 = [15:0], lane 2 = [31:16].
- Misaligned conditions: half with addr[0]=1; word with addr[1:0]!=0; any request with size=11.
- Extension: signed extends bit 7 (byte) or bit 15 (half); unsigned zero-fills. Word loads ignore req_signed.
- Address wrap: no address arithmetic, so the top word index is legal and nothing wraps.
- Reset mid-operation: takes effect at the next edge. A pending RMW write is abandoned and mem_write_en is 0 after that edge, so memory is never partially updated from READ state. No resp_valid is issued for the aborted request.
- req_valid while not IDLE: ignored; no queueing.

Test Plan:
- Word 2 preloaded 0x80FF7F01; signed lb addr 0x009 -> resp_rdata=0x0000007F at acceptance+2, resp_error=0, mem_write_en never high.
- Same word: signed lb 0x00A -> 0xFFFFFFFF; unsigned lb 0x00B -> 0x00000080; signed lh 0x00A -> 0xFFFF80FF; lw 0x008 -> 0x80FF7F01.
- Word 3 preloaded 0x12345678; sb wdata=0x000000AA addr 0x00D:
  - READ, then mem_write_en=1 for exactly one cycle with mem_address=3 and mem_write_data=0x1234AA78.
  - resp_valid at acceptance+3.
  - Subsequent lw 0x00C returns 0x1234AA78.
- sw 0xDEADBEEF addr 0x004 -> single write cycle with mem_address=1, resp at +2; sh 0xBEEF addr 0x006 then lw 0x004 -> 0xBEEFBEEF.
- lw addr 0x006 / lh addr 0x005 / size=11 -> resp_valid at +1 with resp_error=1, resp_rdata=0, no mem_write_en.
- Reset asserted during READ of sb to word 3 -> mem_write_en stays 0, word 3 unchanged (0x12345678), no resp_valid, req_ready=1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/mem_access_unit.sv
// Initiator side of the DataMemory interface. Accepts byte/half/word loads and
// stores, drives the word-wide memory port and returns aligned, extended load
// data. Sub-word stores are read-modify-write since memory has no byte enables.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [1:0]          lane_q, lane_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic                mem_write_en_q, mem_write_en_d;
  logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;

  logic                misaligned;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   merged;

  assign req_ready      = (state_q == StIdle) && !rst;
  assign mem_address    = mem_address_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_write_data = mem_write_data_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;

  // Alignment / legality check on the incoming request.
  always_comb begin
    misaligned = 1'b0;
    unique case (req_size)
      SizeByte: misaligned = 1'b0;
      SizeHalf: misaligned = req_addr[0];
      SizeWord: misaligned = (req_addr[1:0] != 2'b00);
      default:  misaligned = 1'b1;
    endcase
  end

  // Lane extraction and extension of the sampled read word.
  always_comb begin
    rd_byte = mem_read_data[7:0];
    unique case (lane_q)
      2'd0: rd_byte = mem_read_data[7:0];
      2'd1: rd_byte = mem_read_data[15:8];
      2'd2: rd_byte = mem_read_data[23:16];
      2'd3: rd_byte = mem_read_data[31:24];
      default: rd_byte = mem_read_data[7:0];
    endcase
    rd_half = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    unique case (size_q)
      SizeByte: load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      SizeHalf: load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default:  load_ext = mem_read_data;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane(s).
  always_comb begin
    merged = mem_read_data;
    if (size_q == SizeByte) begin
      unique case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_read_data;
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    write_d          = write_q;
    size_d           = size_q;
    signed_d         = signed_q;
    lane_d           = lane_q;
    wdata_d          = wdata_q;
    err_d            = err_q;
    rdata_d          = rdata_q;
    mem_address_d    = mem_address_q;
    mem_write_en_d   = 1'b0;
    mem_write_data_d = mem_write_data_q;
    resp_valid_d     = 1'b0;
    resp_rdata_d     = resp_rdata_q;
    resp_error_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d       = req_write;
          size_d        = req_size;
          signed_d      = req_signed;
          lane_d        = req_addr[1:0];
          wdata_d       = req_wdata[15:0];
          err_d         = misaligned;
          mem_address_d = req_addr[ADDR_W+1:2];
          if (misaligned) begin
            state_d = StResp;
          end else if (req_write && (req_size == SizeWord)) begin
            state_d          = StWrite;
            mem_write_en_d   = 1'b1;
            mem_write_data_d = req_wdata;
          end else begin
            // Loads and sub-word stores both need the current word first.
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (write_q) begin
          state_d          = StWrite;
          mem_write_en_d   = 1'b1;
          mem_write_data_d = merged;
        end else begin
          state_d = StResp;
          rdata_d = load_ext;
        end
      end
      StWrite: begin
        state_d = StResp;
      end
      StResp: begin
        state_d      = StIdle;
        resp_valid_d = 1'b1;
        resp_error_d = err_q;
        resp_rdata_d = (write_q || err_q) ? '0 : rdata_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      write_q          <= 1'b0;
      size_q           <= 2'b00;
      signed_q         <= 1'b0;
      lane_q           <= 2'b00;
      wdata_q          <= '0;
      err_q            <= 1'b0;
      rdata_q          <= '0;
      mem_address_q    <= '0;
      mem_write_en_q   <= 1'b0;
      mem_write_data_q <= '0;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      resp_error_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      write_q          <= write_d;
      size_q           <= size_d;
      signed_q         <= signed_d;
      lane_q           <= lane_d;
      wdata_q          <= wdata_d;
      err_q            <= err_d;
      rdata_q          <= rdata_d;
      mem_address_q    <= mem_address_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_write_data_q <= mem_write_data_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_error_q     <= resp_error_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural DataMemory, scoreboard of expected
// responses, per-feature test tasks.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic [31:0] mem [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          wr_count = 0;
  logic [15:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  int          cyc = 0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .mem_address   (mem_address),
    .mem_write_en  (mem_write_en),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_write_en) begin
      mem[mem_address] <= mem_write_data;
      wr_count         <= wr_count + 1;
      last_waddr       <= mem_address;
      last_wdata       <= mem_write_data;
    end
  end

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Issue one request, then wait (bounded) for its response and compare.
  // skip_sync: drive in the current cycle (back-to-back); hold_chk: check the
  // following cycle for pulse width and resp_rdata hold.
  task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [17:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int exp_wr, input logic [15:0] exp_waddr,
                        input logic [31:0] exp_wdata, input bit skip_sync,
                        input bit hold_chk);
    exp_t e;
    exp_t g;
    int   acc;
    int   wr0;
    bit   seen;
    if (!skip_sync) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready: got %b want 1", name, req_ready);
    end
    wr0 = wr_count;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    g = sb_q.pop_front();
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no resp_valid within 8 cycles", name);
    end else begin
      if (resp_rdata !== g.rdata) begin
        n_fail++;
        $display("FAIL %s rdata: got %h want %h", name, resp_rdata, g.rdata);
      end
      n_checks++;
      if (resp_error !== g.err) begin
        n_fail++;
        $display("FAIL %s error: got %b want %b", name, resp_error, g.err);
      end
      n_checks++;
      if ((cyc - acc) != g.lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", name, cyc - acc, g.lat);
      end
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s ready_at_resp: got %b want 1", name, req_ready);
      end
      n_checks++;
      if ((wr_count - wr0) != exp_wr) begin
        n_fail++;
        $display("FAIL %s write_cycles: got %0d want %0d", name, wr_count - wr0, exp_wr);
      end
      if (exp_wr > 0) begin
        n_checks++;
        if (last_waddr !== exp_waddr || last_wdata !== exp_wdata) begin
          n_fail++;
          $display("FAIL %s write: got addr %h data %h want addr %h data %h", name,
                   last_waddr, last_wdata, exp_waddr, exp_wdata);
        end
      end
      if (hold_chk) begin
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== g.rdata || resp_error !== 1'b0) begin
          n_fail++;
          $display("FAIL %s after_resp: got valid %b rdata %h err %b want 0 %h 0", name,
                   resp_valid, resp_rdata, resp_error, g.rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_error !== 1'b0 ||
        resp_rdata !== '0 || mem_address !== '0 || mem_write_en !== 1'b0 ||
        mem_write_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy %b v %b e %b rd %h a %h we %b wd %h want all 0",
               req_ready, resp_valid, resp_error, resp_rdata, mem_address, mem_write_en,
               mem_write_data);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_loads();
    do_req("lb_s_009", 1'b0, 2'b00, 1'b1, 18'h009, 32'h0, 32'h0000007F, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
    do_req("lb_s_00A", 1'b0, 2'b00, 1'b1, 18'h00A, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
    do_req("lb_u_00B", 1'b0, 2'b00, 1'b0, 18'h00B, 32'h0, 32'h00000080, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
    do_req("lh_s_00A", 1'b0, 2'b01, 1'b1, 18'h00A, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
    do_req("lh_u_00A", 1'b0, 2'b01, 1'b0, 18'h00A, 32'h0, 32'h000080FF, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
    do_req("lw_008", 1'b0, 2'b10, 1'b1, 18'h008, 32'h0, 32'h80FF7F01, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_subword_store();
    do_req("sb_00D", 1'b1, 2'b00, 1'b0, 18'h00D, 32'h000000AA, 32'h0, 1'b0, 3, 1,
           16'h0003, 32'h1234AA78, 1'b0, 1'b1);
    do_req("lw_00C", 1'b0, 2'b10, 1'b0, 18'h00C, 32'h0, 32'h1234AA78, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_word_store();
    do_req("sw_004", 1'b1, 2'b10, 1'b0, 18'h004, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1,
           16'h0001, 32'hDEADBEEF, 1'b0, 1'b1);
    do_req("sh_006", 1'b1, 2'b01, 1'b0, 18'h006, 32'h0000BEEF, 32'h0, 1'b0, 3, 1,
           16'h0001, 32'hBEEFBEEF, 1'b0, 1'b1);
    do_req("lw_004", 1'b0, 2'b10, 1'b0, 18'h004, 32'h0, 32'hBEEFBEEF, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
    // Top word index is a legal address.
    do_req("sw_top", 1'b1, 2'b10, 1'b0, 18'h3FFFC, 32'hA5A5C3C3, 32'h0, 1'b0, 2, 1,
           16'hFFFF, 32'hA5A5C3C3, 1'b0, 1'b1);
    do_req("lb_top", 1'b0, 2'b00, 1'b1, 18'h3FFFF, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_errors();
    do_req("err_lw_006", 1'b0, 2'b10, 1'b0, 18'h006, 32'h0, 32'h0, 1'b1, 1, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
    do_req("err_lh_005", 1'b0, 2'b01, 1'b1, 18'h005, 32'h0, 32'h0, 1'b1, 1, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
    do_req("err_size3", 1'b0, 2'b11, 1'b0, 18'h008, 32'h0, 32'h0, 1'b1, 1, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
    do_req("err_sw_size3", 1'b1, 2'b11, 1'b0, 18'h004, 32'h11111111, 32'h0, 1'b1, 1, 0,
           16'h0, 32'h0, 1'b0, 1'b1);
    do_req("lw_004_after_err", 1'b0, 2'b10, 1'b0, 18'h004, 32'h0, 32'hBEEFBEEF, 1'b0, 2,
           0, 16'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_req("b2b_lw", 1'b0, 2'b10, 1'b0, 18'h008, 32'h0, 32'h80FF7F01, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b0, 1'b0);
    do_req("b2b_err", 1'b0, 2'b01, 1'b0, 18'h009, 32'h0, 32'h0, 1'b1, 1, 0,
           16'h0, 32'h0, 1'b1, 1'b0);
    do_req("b2b_lbu", 1'b0, 2'b00, 1'b0, 18'h00A, 32'h0, 32'h000000FF, 1'b0, 2, 0,
           16'h0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_rmw();
    int wr0;
    bit bad_valid;
    preload(16'h0003, 32'h12345678);
    wr0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 18'h00D; req_wdata = 32'h000000AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rmw_we: got %b want 0", mem_write_en);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rmw_ready: got %b want 1", req_ready);
    end
    bad_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad_valid = 1'b1;
    end
    n_checks++;
    if (bad_valid) begin
      n_fail++;
      $display("FAIL rst_rmw_resp: got resp_valid 1 want 0");
    end
    n_checks++;
    if (wr_count != wr0 || mem[3] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rst_rmw_mem: got writes %0d word3 %h want 0 12345678",
               wr_count - wr0, mem[3]);
    end
  endtask

  initial begin
    test_reset();
    preload(16'h0002, 32'h80FF7F01);
    preload(16'h0003, 32'h12345678);
    test_loads();
    test_subword_store();
    test_word_store();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
